i2s_tx: RTL and testbench

//  Consumer end of the mixer output interface: accepts one signed 24-bit mixed

---
 rtl/i2s_tx_if.sv | 8 +
 rtl/i2s_tx.sv | 105 ++++++++++
 tb/tb_i2s_tx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Sample input bus from the mixer: one-cycle write strobe with its 24-bit sample.
interface i2s_tx_if;
    logic [23:0] i_data;
    logic        i_valid;

    modport master (output i_data, output i_valid);
    modport slave  (input  i_data, input  i_valid);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers mono 24-bit samples in a small FIFO and sends each
// on both LRCK slots, MSB first with the standard one-BCLK delay.
module i2s_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int DEPTH_LOG2 = 2,
    parameter int PRIME      = 2
) (
    input  logic                clk,
    input  logic                rst,
    i2s_tx_if.slave             in_if,
    output logic                o_bclk,
    output logic                o_lrck,
    output logic                o_sdata,
    output logic [DEPTH_LOG2:0] o_fill,
    output logic                o_overrun,
    output logic                o_underrun
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q;
    logic [5:0]            bit_q;
    logic                  bclk_q, lrck_q, sdata_q, ovr_q, und_q;
    logic [23:0]           sample_q;
    logic [23:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0]   fill_q;

    logic       run, wrap, fall, frame, empty, full, pop, wr_ok;
    logic [5:0] nbit;
    logic [4:0] pos, idx;
    logic       sbit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && fill_q >= (DEPTH_LOG2+1)'(PRIME)) state_d = RUN;
    end

    always_comb begin
        run   = (state_q == RUN);
        wrap  = run && (div_q == DW'(BCLK_DIV - 1));
        fall  = wrap && bclk_q;
        frame = fall && (bit_q == 6'd63);
        empty = (fill_q == '0);
        full  = (fill_q == (DEPTH_LOG2+1)'(DEPTH));
        pop   = frame && !empty;
        // A same-cycle pop frees the head slot, so a write to a full FIFO still fits.
        wr_ok = in_if.i_valid && (!full || pop);
        nbit  = bit_q + 6'd1;
        pos   = nbit[4:0];
        idx   = 5'd24 - pos;
        sbit  = (pos >= 5'd1 && pos <= 5'd24) ? sample_q[idx] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_q] <= in_if.i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            bit_q    <= 6'd63;
            bclk_q   <= 1'b0;
            lrck_q   <= 1'b0;
            sdata_q  <= 1'b0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
            sample_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            fill_q   <= '0;
        end else begin
            ovr_q  <= in_if.i_valid && !wr_ok;
            und_q  <= frame && empty;
            fill_q <= fill_q + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(pop);
            if (wr_ok) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            if (run) begin
                div_q <= wrap ? '0 : div_q + 1'b1;
                if (wrap) bclk_q <= ~bclk_q;
            end
            if (fall) begin
                bit_q   <= nbit;
                lrck_q  <= nbit[5];
                sdata_q <= sbit;
            end
            if (frame) sample_q <= empty ? '0 : mem_q[rd_q];
        end
    end

    assign o_bclk     = bclk_q;
    assign o_lrck     = lrck_q;
    assign o_sdata    = sdata_q;
    assign o_fill     = fill_q;
    assign o_overrun  = ovr_q;
    assign o_underrun = und_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: cycle model with a sample scoreboard for BCLK_DIV=4, plus
// clock-ratio checks on a BCLK_DIV=1 instance.
module tb_i2s_tx;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_tx_if bus ();
    i2s_tx_if bus1 ();

    logic       bclk, lrck, sdata, ovr, und;
    logic [2:0] fill;
    logic       b1, l1, s1, ovr1, und1;
    logic [2:0] fill1;

    i2s_tx #(.BCLK_DIV(D), .DEPTH_LOG2(2), .PRIME(2)) dut (
        .clk(clk), .rst(rst), .in_if(bus),
        .o_bclk(bclk), .o_lrck(lrck), .o_sdata(sdata),
        .o_fill(fill), .o_overrun(ovr), .o_underrun(und)
    );

    i2s_tx #(.BCLK_DIV(1), .DEPTH_LOG2(2), .PRIME(2)) dut1 (
        .clk(clk), .rst(rst), .in_if(bus1),
        .o_bclk(b1), .o_lrck(l1), .o_sdata(s1),
        .o_fill(fill1), .o_overrun(ovr1), .o_underrun(und1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] fw(input logic [23:0] s);
        return {1'b0, s, 7'b0, 1'b0, s, 7'b0};
    endfunction

    // Reference model: sample queue is the scoreboard, timing derived from RUN cycle count.
    logic [23:0] sbq[$];
    int          rc, mbit, mp, mpre;
    bit          mrun;
    logic        mb, ml, ms, mo, mu;
    logic [2:0]  mf;
    logic [23:0] msamp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sbq.delete();
            rc = 0; mbit = 63; mrun = 0;
            mb = 0; ml = 0; ms = 0; mo = 0; mu = 0; mf = 0; msamp = '0;
        end else begin
            mpre = sbq.size();
            mo = 0; mu = 0;
            if (mrun) begin
                rc++;
                mb = ((rc / D) % 2) == 1;
                if (rc % (2 * D) == 0) begin
                    mbit = (mbit + 1) % 64;
                    if (mbit == 0) begin
                        if (sbq.size() > 0) msamp = sbq.pop_front();
                        else begin msamp = '0; mu = 1; end
                    end
                    ml = (mbit >= 32);
                    mp = mbit % 32;
                    ms = (mp >= 1 && mp <= 24) ? msamp[24 - mp] : 1'b0;
                end
            end
            if (bus.i_valid) begin
                if (sbq.size() < 4) sbq.push_back(bus.i_data);
                else mo = 1;
            end
            if (!mrun && mpre >= 2) mrun = 1;
            mf = 3'(sbq.size());
        end
    end

    logic        pb = 0, pl = 0, fell = 0, d1pb = 0, d1pl = 0;
    int          rise_t = 0, ltog_t = 0, d1rise_t = 0, d1ltog_t = 0;
    int          und_cnt = 0, ovr_cnt = 0, fr_cnt = 0;
    logic [63:0] fr = '0, fr_done = '0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        check("bclk", bclk, mb);
        check("lrck", lrck, ml);
        check("sdata", sdata, ms);
        check("fill", fill, mf);
        check("overrun", ovr, mo);
        check("underrun", und, mu);
        if (ovr) ovr_cnt++;
        if (und) und_cnt++;
        fell = pb && !bclk;
        if (fell) begin
            fr = {fr[62:0], sdata};
            if (mbit == 63) begin fr_done = fr; fr_cnt++; end
        end
        if (rst) begin
            rise_t = 0; ltog_t = 0; d1rise_t = 0; d1ltog_t = 0;
        end else begin
            if (!pb && bclk) begin
                if (rise_t > 0) check("bclk_period_div4", cyc - rise_t, 2 * D);
                rise_t = cyc;
            end
            if (lrck != pl) begin
                check("lrck_on_fall_div4", {pb, bclk}, 2'b10);
                if (ltog_t > 0) check("lrck_interval_div4", cyc - ltog_t, 64 * D);
                ltog_t = cyc;
            end
            if (!d1pb && b1) begin
                if (d1rise_t > 0) check("bclk_period_div1", cyc - d1rise_t, 2);
                d1rise_t = cyc;
            end
            if (l1 != d1pl) begin
                check("lrck_on_fall_div1", {d1pb, b1}, 2'b10);
                if (d1ltog_t > 0) check("lrck_interval_div1", cyc - d1ltog_t, 64);
                d1ltog_t = cyc;
            end
        end
        pb = bclk; pl = lrck; d1pb = b1; d1pl = l1;
    endtask

    task automatic write(input logic [23:0] s, input bit both);
        bus.i_data = s; bus.i_valid = 1'b1;
        if (both) begin bus1.i_data = s; bus1.i_valid = 1'b1; end
        tick();
    endtask

    task automatic idle();
        bus.i_valid = 1'b0; bus1.i_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int target;
        target = fr_cnt + n;
        for (int i = 0; i < n * 600 && fr_cnt < target; i++) tick();
        check("frame_wait", fr_cnt, target);
    endtask

    logic [23:0] tail [4];
    int lat, o0, u0;

    initial begin
        bus.i_data = '0; bus.i_valid = 1'b0;
        bus1.i_data = '0; bus1.i_valid = 1'b0;
        repeat (3) tick();
        check("rst_fill", fill, 0);
        check("rst_bclk", bclk, 0);
        rst = 1'b0;
        repeat (5) tick();

        // PRIME reached on second write; first falling edge 1+2*BCLK_DIV clk later
        write(24'h800001, 1'b1);
        write(24'h7FFFFF, 1'b1);
        idle();
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); lat++;
            if (fell) break;
        end
        check("latency", lat, 1 + 2 * D);
        check("fill_after_pop", fill, 1);
        wait_frames(1);
        check("frame_800001", fr_done, fw(24'h800001));
        wait_frames(1);
        check("frame_7fffff", fr_done, fw(24'h7FFFFF));

        // drained: exactly one underrun per frame and silent data
        u0 = und_cnt;
        wait_frames(1);
        check("underrun_per_frame", und_cnt - u0, 1);
        check("frame_silent", fr_done, 64'h0);

        // five writes between pops: fifth dropped
        repeat (20) tick();
        o0 = ovr_cnt;
        write(24'h111111, 1'b0);
        write(24'h222222, 1'b0);
        write(24'h333333, 1'b0);
        write(24'h444444, 1'b0);
        write(24'h555555, 1'b0);
        idle();
        tick();
        check("overrun_count", ovr_cnt - o0, 1);
        check("fill_full", fill, 4);

        // write while full on the frame-start pop edge
        for (int i = 0; i < 600; i++) begin
            if (mrun && ((rc + 1) % (2 * D) == 0) && mbit == 63) break;
            tick();
        end
        check("pop_edge_found", mbit, 63);
        o0 = ovr_cnt;
        write(24'hABCDEF, 1'b0);
        idle();
        check("no_overrun_on_pop", ovr_cnt - o0, 0);
        check("fill_stays_full", fill, 4);
        wait_frames(1);
        check("head_unchanged", fr_done, fw(24'h111111));
        tail[0] = 24'h222222; tail[1] = 24'h333333;
        tail[2] = 24'h444444; tail[3] = 24'hABCDEF;
        for (int k = 0; k < 4; k++) begin
            wait_frames(1);
            check("drain_order", fr_done, fw(tail[k]));
        end

        // reset mid-frame
        repeat (100) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_bclk", bclk, 0);
        check("midrst_lrck", lrck, 0);
        check("midrst_sdata", sdata, 0);
        check("midrst_fill", fill, 0);
        check("midrst_flags", {ovr, und}, 2'b00);
        check("midrst_bclk_div1", b1, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        check("idle_bclk", bclk, 0);
        check("idle_fill", fill, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
